triangle_decoder: RTL

- Receive-side counterpart to the triangle waveform generator. Consumes a 16-bit unsigned sample stream and recovers its shape.
- Tracks ramp direction with a hysteresis band and detects turning points.
- Reports peak max/min, rise/fall segment lengths and full period, in valid samples.
- Sits on the sample bus after the generator (or after an ADC capture path) and feeds status/display logic.

---
 rtl/triangle_decoder.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/triangle_decoder.sv
// triangle_decoder: recovers shape (direction, peaks, segment lengths, period)
// of a 16-bit triangle sample stream. Optional watchdog: TRI_DEC_TIMEOUT_EN.
module triangle_decoder #(
    parameter int unsigned HYST       = 16,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [15:0]      sample,
    output logic             rising,
    output logic [15:0]      peak_max,
    output logic [15:0]      peak_min,
    output logic [CNT_W-1:0] rise_len,
    output logic [CNT_W-1:0] fall_len,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked
);

    localparam logic [16:0]      HYST_X   = 17'(HYST);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);

    if (HYST < 1 || HYST > 32767) begin : g_bad_hyst
        $error("triangle_decoder: HYST out of range");
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
        $error("triangle_decoder: LOCK_COUNT out of range");
    end
    if (CNT_W < 2 || TIMEOUT < 1) begin : g_bad_cnt
        $error("triangle_decoder: CNT_W or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      ref_q, ref_d;
    logic [15:0]      run_max_q, run_max_d;
    logic [15:0]      run_min_q, run_min_d;
    logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
    logic             have_ref_q, have_ref_d;
    logic             have_rise_q, have_rise_d;
    logic             have_fall_q, have_fall_d;
    logic             from_turn_q, from_turn_d;
    logic [3:0]       lock_cnt_q, lock_cnt_d;
    logic             rising_q, rising_d;
    logic [15:0]      peak_max_q, peak_max_d;
    logic [15:0]      peak_min_q, peak_min_d;
    logic [CNT_W-1:0] rise_len_q, rise_len_d;
    logic [CNT_W-1:0] fall_len_q, fall_len_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;

    logic [CNT_W-1:0] seg_next;
    logic [CNT_W-1:0] rise_new;
    logic [CNT_W:0]   period_sum;
    logic [16:0]      smp_x;
    logic             up_hit, down_hit, max_turn, min_turn;
    logic             turn;

`ifdef TRI_DEC_TIMEOUT_EN
    logic [31:0]      wd_cnt_q, wd_cnt_d;
`endif

    // All compares are done one bit wider so sample+HYST can never wrap.
    always_comb begin
        smp_x    = {1'b0, sample};
        seg_next = (seg_cnt_q == CNT_MAX) ? CNT_MAX : seg_cnt_q + 1'b1;
        up_hit   = smp_x >= ({1'b0, ref_q} + HYST_X);
        down_hit = (smp_x + HYST_X) <= {1'b0, ref_q};
        max_turn = (smp_x + HYST_X) <= {1'b0, run_max_q};
        min_turn = smp_x >= ({1'b0, run_min_q} + HYST_X);
    end

    always_comb begin
        state_d        = state_q;
        ref_d          = ref_q;
        run_max_d      = run_max_q;
        run_min_d      = run_min_q;
        seg_cnt_d      = seg_cnt_q;
        have_ref_d     = have_ref_q;
        have_rise_d    = have_rise_q;
        have_fall_d    = have_fall_q;
        from_turn_d    = from_turn_q;
        lock_cnt_d     = lock_cnt_q;
        rising_d       = rising_q;
        peak_max_d     = peak_max_q;
        peak_min_d     = peak_min_q;
        rise_len_d     = rise_len_q;
        fall_len_d     = fall_len_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        rise_new       = rise_len_q;
        period_sum     = '0;
        turn           = 1'b0;
`ifdef TRI_DEC_TIMEOUT_EN
        wd_cnt_d       = wd_cnt_q;
`endif

        if (sample_valid) begin
            seg_cnt_d = seg_next;
            case (state_q)
                ACQUIRE: begin
                    if (!have_ref_q) begin
                        ref_d      = sample;
                        have_ref_d = 1'b1;
                    end else if (up_hit) begin
                        state_d     = RISING;
                        run_max_d   = sample;
                        rising_d    = 1'b1;
                        seg_cnt_d   = '0;
                        from_turn_d = 1'b0;
                    end else if (down_hit) begin
                        state_d     = FALLING;
                        run_min_d   = sample;
                        rising_d    = 1'b0;
                        seg_cnt_d   = '0;
                        from_turn_d = 1'b0;
                    end
                end
                RISING: begin
                    if (sample > run_max_q) begin
                        run_max_d = sample;
                    end else if (max_turn) begin
                        turn        = 1'b1;
                        peak_max_d  = run_max_q;
                        state_d     = FALLING;
                        run_min_d   = sample;
                        rising_d    = 1'b0;
                        seg_cnt_d   = '0;
                        from_turn_d = 1'b1;
                        // A segment entered from ACQUIRE is partial, so it is not measured.
                        if (from_turn_q) begin
                            rise_new    = seg_next;
                            rise_len_d  = seg_next;
                            have_rise_d = 1'b1;
                        end
                        if ((from_turn_q || have_rise_q) && have_fall_q) begin
                            period_sum     = {1'b0, rise_new} + {1'b0, fall_len_q};
                            period_d       = period_sum[CNT_W] ? CNT_MAX : period_sum[CNT_W-1:0];
                            period_valid_d = 1'b1;
                            if (lock_cnt_q < LOCK_TGT) begin
                                lock_cnt_d = lock_cnt_q + 4'd1;
                            end
                        end
                    end
                end
                FALLING: begin
                    if (sample < run_min_q) begin
                        run_min_d = sample;
                    end else if (min_turn) begin
                        turn        = 1'b1;
                        peak_min_d  = run_min_q;
                        state_d     = RISING;
                        run_max_d   = sample;
                        rising_d    = 1'b1;
                        seg_cnt_d   = '0;
                        from_turn_d = 1'b1;
                        if (from_turn_q) begin
                            fall_len_d  = seg_next;
                            have_fall_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                end
            endcase

`ifdef TRI_DEC_TIMEOUT_EN
            // Watchdog only runs while tracking; peaks and lengths deliberately survive it.
            if (state_q == ACQUIRE || turn) begin
                wd_cnt_d = '0;
            end else if (wd_cnt_q + 32'd1 >= TIMEOUT) begin
                wd_cnt_d    = '0;
                state_d     = ACQUIRE;
                have_ref_d  = 1'b0;
                have_rise_d = 1'b0;
                have_fall_d = 1'b0;
                from_turn_d = 1'b0;
                lock_cnt_d  = '0;
                seg_cnt_d   = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + 32'd1;
            end
`endif
        end

        locked_d = (lock_cnt_d >= LOCK_TGT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ACQUIRE;
            ref_q          <= '0;
            run_max_q      <= '0;
            run_min_q      <= '0;
            seg_cnt_q      <= '0;
            have_ref_q     <= 1'b0;
            have_rise_q    <= 1'b0;
            have_fall_q    <= 1'b0;
            from_turn_q    <= 1'b0;
            lock_cnt_q     <= '0;
            rising_q       <= 1'b0;
            peak_max_q     <= '0;
            peak_min_q     <= '0;
            rise_len_q     <= '0;
            fall_len_q     <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
`ifdef TRI_DEC_TIMEOUT_EN
            wd_cnt_q       <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ref_q          <= ref_d;
            run_max_q      <= run_max_d;
            run_min_q      <= run_min_d;
            seg_cnt_q      <= seg_cnt_d;
            have_ref_q     <= have_ref_d;
            have_rise_q    <= have_rise_d;
            have_fall_q    <= have_fall_d;
            from_turn_q    <= from_turn_d;
            lock_cnt_q     <= lock_cnt_d;
            rising_q       <= rising_d;
            peak_max_q     <= peak_max_d;
            peak_min_q     <= peak_min_d;
            rise_len_q     <= rise_len_d;
            fall_len_q     <= fall_len_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
`ifdef TRI_DEC_TIMEOUT_EN
            wd_cnt_q       <= wd_cnt_d;
`endif
        end
    end

    assign rising       = rising_q;
    assign peak_max     = peak_max_q;
    assign peak_min     = peak_min_q;
    assign rise_len     = rise_len_q;
    assign fall_len     = fall_len_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;

endmodule
